circuito_exp5: RTL and testbench
================================

// Module: circuito_exp5
// PURPOSE
//  Sequence-memory game ("Genius"): round k (k=0..15) requires the player to repeat ROM entries 0..k on 4 one-hot buttons.
//  Top level of the experiment: FSM control unit + datapath (address/round/timeout counters, play register, edge detector, ROM, comparators).
//  Ends in win (all 16 rounds), loss (wrong button) or timeout; 7-seg debug outputs for the FPGA board.
// PARAMETERS
//  TIMEOUT  5000  cycles allowed in wait-for-play before timeout (5 s at 1 kHz)
// PORTS
//  clock           in   1  system clock; sole clock domain
//  reset           in   1  asynchronous, active-low reset
//  jogar           in   1  start/restart game (level, sampled each cycle)
//  botoes          in   4  player buttons, one-hot
//  ganhou          out  1  game won
//  perdeu          out  1  game lost (wrong play or timeout)
//  pronto          out  1  game finished (win/loss/timeout)
//  leds            out  4  last registered play
//  db_igual        out  1  registered play == ROM data
//  db_contagem     out  7  7-seg of address counter
//  db_memoria      out  7  7-seg of ROM data
//  db_estado       out  7  7-seg of FSM state code
//  db_jogadafeita  out  7  7-seg of registered play
//  db_sequencia    out  7  7-seg of round counter
//  db_clock        out  1  copy of clock
//  db_iniciar      out  1  copy of jogar
//  db_fimseq       out  1  round counter == 15
//  db_igualseq     out  1  address counter == round counter
//  db_igualjogada  out  1  same as db_igual
//  db_tem_jogada   out  1  OR of botoes (raw)
//  db_timeout      out  1  timeout occurred (high in fim_timeout)
// BEHAVIOUR
//  Reset (reset=0): FSM->inicial; counters, play register, edge detector cleared; ganhou=perdeu=pronto=0, leds=0.
//  ROM 16x4, address = address counter: 1,2,4,8,4,2,1,1,2,2,4,4,8,8,1,4 (hex, addr 0..15).
//  Play detect: registered rising edge of |botoes -> 1-cycle pulse "jogada"; held buttons give one pulse only.
//  7-seg: active-low, bits {g,f,e,d,c,b,a}, hex 0-F (0=1000000, 1=1111001, E=0000110).
//  States (db_estado code): inicial 0, preparacao 1, nova_seq 2, espera 3, registra 4,
//   comparacao 5, prox_jogada 6, prox_seq 7, fim_ganhou A, fim_timeout D, fim_perdeu E.
//  inicial: jogar=1 -> preparacao.
//  preparacao: clear round counter, play register, outputs -> nova_seq.
//  nova_seq: clear address counter and timeout counter -> espera.
//  espera: timeout counter increments; jogada -> registra; count reaches TIMEOUT-1 -> fim_timeout.
//  registra: load botoes into play register -> comparacao.
//  comparacao: mismatch -> fim_perdeu; match & address<round -> prox_jogada;
//   match & address==round & round<15 -> prox_seq; match & address==round==15 -> fim_ganhou.
//  prox_jogada: address+1, clear timeout counter -> espera.  prox_seq: round+1 -> nova_seq.
//  fim_ganhou: ganhou=1,pronto=1. fim_perdeu: perdeu=1,pronto=1. fim_timeout: perdeu=1,pronto=1,db_timeout=1.
//  Final states hold outputs, ignore botoes; jogar=1 -> preparacao (new game, flags cleared).
//  jogar ignored outside inicial/final states. Counters 4-bit, never wrap in legal flow.
//  Async reset mid-game returns to inicial immediately; no partial state survives.
// TESTING
//  reset=0 1 cycle, idle 15 cycles -> db_estado=0 code, pronto=ganhou=perdeu=0.
//  jogar=1 5 cycles, press 0001 10 cycles -> round 0 passes, db_sequencia=1, state back to espera (3).
//  round 1: press 0001 then 1111 -> fim_perdeu: perdeu=1, pronto=1, db_estado=E, leds=1111; later presses ignored.
//  full game: enter correct prefixes of ROM for rounds 0..15 (10 cycles on, 10 off) -> ganhou=1, pronto=1, db_estado=A.
//  after jogar, no press for TIMEOUT cycles -> perdeu=1, db_timeout=1, db_estado=D.
//  button held 10 cycles -> exactly one registered play (db_contagem increments by 1 only).

Source files
------------

// File: rtl/circuito_exp5.sv
// Sequence-memory game ("Genius"): 16 rounds replaying ROM prefixes on four one-hot buttons.
// Control FSM plus datapath (address/round/timeout counters, play register, edge detector, ROM).
module circuito_exp5 #(
    parameter int unsigned TIMEOUT = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       jogar,
    input  logic [3:0] botoes,
    output logic       ganhou,
    output logic       perdeu,
    output logic       pronto,
    output logic [3:0] leds,
    output logic       db_igual,
    output logic [6:0] db_contagem,
    output logic [6:0] db_memoria,
    output logic [6:0] db_estado,
    output logic [6:0] db_jogadafeita,
    output logic [6:0] db_sequencia,
    output logic       db_clock,
    output logic       db_iniciar,
    output logic       db_fimseq,
    output logic       db_igualseq,
    output logic       db_igualjogada,
    output logic       db_tem_jogada,
    output logic       db_timeout
);

    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [3:0] {
        S_INICIAL     = 4'h0,
        S_PREPARACAO  = 4'h1,
        S_NOVA_SEQ    = 4'h2,
        S_ESPERA      = 4'h3,
        S_REGISTRA    = 4'h4,
        S_COMPARACAO  = 4'h5,
        S_PROX_JOGADA = 4'h6,
        S_PROX_SEQ    = 4'h7,
        S_FIM_GANHOU  = 4'hA,
        S_FIM_TIMEOUT = 4'hD,
        S_FIM_PERDEU  = 4'hE
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [3:0]       r_addr;
    logic [3:0]       r_round;
    logic [TMO_W-1:0] r_tmo;
    logic [3:0]       r_play;
    logic             r_tem_prev;
    logic             r_jogada;
    logic             r_ganhou;
    logic             r_perdeu;
    logic             r_pronto;
    logic             r_timeout;

    logic             w_zera_round;
    logic             w_zera_play;
    logic             w_zera_addr;
    logic             w_zera_tmo;
    logic             w_conta_tmo;
    logic             w_carrega;
    logic             w_conta_addr;
    logic             w_conta_round;

    logic [3:0]       w_rom;
    logic             w_igual;
    logic             w_igualseq;
    logic             w_fimseq;
    logic             w_tmo_end;
    logic             w_tem_jogada;

    function automatic logic [3:0] rom_data(input logic [3:0] a);
        case (a)
            4'h0: rom_data = 4'h1;
            4'h1: rom_data = 4'h2;
            4'h2: rom_data = 4'h4;
            4'h3: rom_data = 4'h8;
            4'h4: rom_data = 4'h4;
            4'h5: rom_data = 4'h2;
            4'h6: rom_data = 4'h1;
            4'h7: rom_data = 4'h1;
            4'h8: rom_data = 4'h2;
            4'h9: rom_data = 4'h2;
            4'hA: rom_data = 4'h4;
            4'hB: rom_data = 4'h4;
            4'hC: rom_data = 4'h8;
            4'hD: rom_data = 4'h8;
            4'hE: rom_data = 4'h1;
            default: rom_data = 4'h4;
        endcase
    endfunction

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex7seg(input logic [3:0] v);
        case (v)
            4'h0: hex7seg = 7'b1000000;
            4'h1: hex7seg = 7'b1111001;
            4'h2: hex7seg = 7'b0100100;
            4'h3: hex7seg = 7'b0110000;
            4'h4: hex7seg = 7'b0011001;
            4'h5: hex7seg = 7'b0010010;
            4'h6: hex7seg = 7'b0000010;
            4'h7: hex7seg = 7'b1111000;
            4'h8: hex7seg = 7'b0000000;
            4'h9: hex7seg = 7'b0010000;
            4'hA: hex7seg = 7'b0001000;
            4'hB: hex7seg = 7'b0000011;
            4'hC: hex7seg = 7'b1000110;
            4'hD: hex7seg = 7'b0100001;
            4'hE: hex7seg = 7'b0000110;
            default: hex7seg = 7'b0001110;
        endcase
    endfunction

    assign w_rom        = rom_data(r_addr);
    assign w_igual      = (r_play == w_rom);
    assign w_igualseq   = (r_addr == r_round);
    assign w_fimseq     = (r_round == 4'hF);
    assign w_tmo_end    = (r_tmo == TMO_W'(TIMEOUT - 1));
    assign w_tem_jogada = |botoes;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_INICIAL;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_INICIAL:     if (jogar) w_next_state = S_PREPARACAO;
            S_PREPARACAO:  w_next_state = S_NOVA_SEQ;
            S_NOVA_SEQ:    w_next_state = S_ESPERA;
            S_ESPERA: begin
                if (r_jogada)       w_next_state = S_REGISTRA;
                else if (w_tmo_end) w_next_state = S_FIM_TIMEOUT;
            end
            S_REGISTRA:    w_next_state = S_COMPARACAO;
            S_COMPARACAO: begin
                if (!w_igual)         w_next_state = S_FIM_PERDEU;
                else if (!w_igualseq) w_next_state = S_PROX_JOGADA;
                else if (!w_fimseq)   w_next_state = S_PROX_SEQ;
                else                  w_next_state = S_FIM_GANHOU;
            end
            S_PROX_JOGADA: w_next_state = S_ESPERA;
            S_PROX_SEQ:    w_next_state = S_NOVA_SEQ;
            S_FIM_GANHOU, S_FIM_PERDEU, S_FIM_TIMEOUT:
                           if (jogar) w_next_state = S_PREPARACAO;
            default:       w_next_state = S_INICIAL;
        endcase
    end

    always_comb begin
        w_zera_round  = 1'b0;
        w_zera_play   = 1'b0;
        w_zera_addr   = 1'b0;
        w_zera_tmo    = 1'b0;
        w_conta_tmo   = 1'b0;
        w_carrega     = 1'b0;
        w_conta_addr  = 1'b0;
        w_conta_round = 1'b0;
        case (r_state)
            S_PREPARACAO: begin
                w_zera_round = 1'b1;
                w_zera_play  = 1'b1;
            end
            S_NOVA_SEQ: begin
                w_zera_addr = 1'b1;
                w_zera_tmo  = 1'b1;
            end
            S_ESPERA:      w_conta_tmo = 1'b1;
            S_REGISTRA:    w_carrega   = 1'b1;
            S_PROX_JOGADA: begin
                w_conta_addr = 1'b1;
                w_zera_tmo   = 1'b1;
            end
            S_PROX_SEQ:    w_conta_round = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_addr  <= 4'd0;
            r_round <= 4'd0;
            r_tmo   <= '0;
            r_play  <= 4'd0;
        end else begin
            if (w_zera_addr)       r_addr <= 4'd0;
            else if (w_conta_addr) r_addr <= r_addr + 4'd1;
            if (w_zera_round)       r_round <= 4'd0;
            else if (w_conta_round) r_round <= r_round + 4'd1;
            if (w_zera_tmo)       r_tmo <= '0;
            else if (w_conta_tmo) r_tmo <= r_tmo + TMO_W'(1);
            if (w_zera_play)    r_play <= 4'd0;
            else if (w_carrega) r_play <= botoes;
        end
    end

    // One pulse per press: rising edge of any button, held buttons do not repeat
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tem_prev <= 1'b0;
            r_jogada   <= 1'b0;
        end else begin
            r_tem_prev <= w_tem_jogada;
            r_jogada   <= w_tem_jogada & ~r_tem_prev;
        end
    end

    // Result flags follow the state being entered so they line up with db_estado
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ganhou  <= 1'b0;
            r_perdeu  <= 1'b0;
            r_pronto  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_ganhou  <= (w_next_state == S_FIM_GANHOU);
            r_perdeu  <= (w_next_state == S_FIM_PERDEU) || (w_next_state == S_FIM_TIMEOUT);
            r_pronto  <= (w_next_state == S_FIM_GANHOU) || (w_next_state == S_FIM_PERDEU) ||
                         (w_next_state == S_FIM_TIMEOUT);
            r_timeout <= (w_next_state == S_FIM_TIMEOUT);
        end
    end

    assign ganhou         = r_ganhou;
    assign perdeu         = r_perdeu;
    assign pronto         = r_pronto;
    assign db_timeout     = r_timeout;
    assign leds           = r_play;
    assign db_igual       = w_igual;
    assign db_igualjogada = w_igual;
    assign db_igualseq    = w_igualseq;
    assign db_fimseq      = w_fimseq;
    assign db_contagem    = hex7seg(r_addr);
    assign db_memoria     = hex7seg(w_rom);
    assign db_estado      = hex7seg(r_state);
    assign db_jogadafeita = hex7seg(r_play);
    assign db_sequencia   = hex7seg(r_round);
    assign db_clock       = clock;
    assign db_iniciar     = jogar;
    assign db_tem_jogada  = w_tem_jogada;

endmodule

// File: tb/tb_circuito_exp5.sv
// Scoreboard bench for circuito_exp5: stimulus queues expected snapshots, a negedge monitor compares them.
module tb_circuito_exp5;

    logic       clock;
    logic       reset;
    logic       jogar;
    logic [3:0] botoes;
    logic       ganhou, perdeu, pronto, db_igual, db_clock, db_iniciar;
    logic       db_fimseq, db_igualseq, db_igualjogada, db_tem_jogada, db_timeout;
    logic [3:0] leds;
    logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita, db_sequencia;

    circuito_exp5 #(.TIMEOUT(5000)) dut (
        .clock(clock), .reset(reset), .jogar(jogar), .botoes(botoes),
        .ganhou(ganhou), .perdeu(perdeu), .pronto(pronto), .leds(leds),
        .db_igual(db_igual), .db_contagem(db_contagem), .db_memoria(db_memoria),
        .db_estado(db_estado), .db_jogadafeita(db_jogadafeita), .db_sequencia(db_sequencia),
        .db_clock(db_clock), .db_iniciar(db_iniciar), .db_fimseq(db_fimseq),
        .db_igualseq(db_igualseq), .db_igualjogada(db_igualjogada),
        .db_tem_jogada(db_tem_jogada), .db_timeout(db_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hand-written 7-seg codes {g,f,e,d,c,b,a}, active low
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;

    typedef struct {
        string      name;
        logic [6:0] estado;
        logic       ganhou, perdeu, pronto, tmo;
        logic [3:0] leds;
        logic [6:0] seq, cont;
        bit         c_leds, c_seq, c_cont;
    } exp_t;

    exp_t q[$];
    logic chk_req = 1'b0;
    int   n_chk   = 0;
    int   n_fail  = 0;
    logic [3:0] rom_tb [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                                4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};

    task automatic cmp(input string nm, input string f, input logic [6:0] act, input logic [6:0] ex);
        n_chk++;
        if (act !== ex) begin
            n_fail++;
            $display("FAIL %s.%s: got %b expected %b", nm, f, act, ex);
        end
    endtask

    // Monitor: pops one expected snapshot per sample request and compares it with the outputs
    always @(negedge clock) begin
        if (chk_req) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL scoreboard: sample requested with empty queue");
            end else begin
                exp_t e;
                e = q.pop_front();
                cmp(e.name, "estado", db_estado, e.estado);
                cmp(e.name, "ganhou", 7'(ganhou), 7'(e.ganhou));
                cmp(e.name, "perdeu", 7'(perdeu), 7'(e.perdeu));
                cmp(e.name, "pronto", 7'(pronto), 7'(e.pronto));
                cmp(e.name, "timeout", 7'(db_timeout), 7'(e.tmo));
                if (e.c_leds) cmp(e.name, "leds", 7'(leds), 7'(e.leds));
                if (e.c_seq)  cmp(e.name, "sequencia", db_sequencia, e.seq);
                if (e.c_cont) cmp(e.name, "contagem", db_contagem, e.cont);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] b, input int on, input int off);
        botoes = b;
        tick(on);
        botoes = 4'b0000;
        tick(off);
    endtask

    task automatic start_game();
        jogar = 1'b1;
        tick(5);
        jogar = 1'b0;
    endtask

    task automatic expect_out(input string nm, input logic [6:0] st,
                              input logic g, input logic p, input logic pr, input logic t,
                              input bit cl, input logic [3:0] l,
                              input bit cs, input logic [6:0] s,
                              input bit cc, input logic [6:0] c);
        exp_t e;
        e.name = nm; e.estado = st; e.ganhou = g; e.perdeu = p; e.pronto = pr; e.tmo = t;
        e.c_leds = cl; e.leds = l; e.c_seq = cs; e.seq = s; e.c_cont = cc; e.cont = c;
        q.push_back(e);
        chk_req = 1'b1;
        @(negedge clock);
        #1 chk_req = 1'b0;
    endtask

    initial begin
        reset  = 1'b0;
        jogar  = 1'b0;
        botoes = 4'b0000;
        tick(1);
        reset = 1'b1;
        tick(15);
        expect_out("reset_idle", SEG_0, 0, 0, 0, 0, 1, 4'h0, 1, SEG_0, 1, SEG_0);

        // Round 0: single correct press advances to round 1
        start_game();
        press(4'b0001, 10, 10);
        expect_out("round0_pass", SEG_3, 0, 0, 0, 0, 1, 4'h1, 1, SEG_1, 1, SEG_0);

        jogar = 1'b1;
        tick(3);
        jogar = 1'b0;
        tick(2);
        expect_out("jogar_ignored", SEG_3, 0, 0, 0, 0, 0, 4'h0, 1, SEG_1, 1, SEG_0);

        // Round 1: correct first entry, then a wrong one
        press(4'b0001, 10, 10);
        expect_out("round1_step", SEG_3, 0, 0, 0, 0, 0, 4'h0, 1, SEG_1, 1, SEG_1);
        press(4'b1111, 10, 10);
        expect_out("lose", SEG_E, 0, 1, 1, 0, 1, 4'hF, 0, 7'h0, 0, 7'h0);
        press(4'b0010, 10, 10);
        expect_out("lose_hold", SEG_E, 0, 1, 1, 0, 1, 4'hF, 0, 7'h0, 0, 7'h0);

        // Full game from a finished state: flags clear on restart
        start_game();
        expect_out("restart", SEG_3, 0, 0, 0, 0, 1, 4'h0, 1, SEG_0, 1, SEG_0);
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i <= k; i++) press(rom_tb[i], 10, 10);
            if (k == 7) expect_out("mid_game", SEG_3, 0, 0, 0, 0, 1, 4'h1, 1, SEG_8, 1, SEG_0);
        end
        expect_out("win", SEG_A, 1, 0, 1, 0, 1, 4'h4, 0, 7'h0, 0, 7'h0);

        // Held button yields one play; then timeout
        start_game();
        press(4'b0001, 10, 10);
        press(4'b0001, 30, 10);
        expect_out("held_once", SEG_3, 0, 0, 0, 0, 1, 4'h1, 1, SEG_1, 1, SEG_1);
        tick(4900);
        expect_out("pre_timeout", SEG_3, 0, 0, 0, 0, 0, 4'h0, 0, 7'h0, 0, 7'h0);
        tick(200);
        expect_out("timeout", SEG_D, 0, 1, 1, 1, 0, 4'h0, 0, 7'h0, 0, 7'h0);

        // Async reset mid-game clears everything without a clock edge
        start_game();
        press(4'b0001, 10, 10);
        #2 reset = 1'b0;
        expect_out("async_reset", SEG_0, 0, 0, 0, 0, 1, 4'h0, 1, SEG_0, 1, SEG_0);
        tick(1);
        reset = 1'b1;
        tick(3);
        expect_out("after_reset", SEG_0, 0, 0, 0, 0, 1, 4'h0, 1, SEG_0, 1, SEG_0);

        tick(2);
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
